// File: rtl/control_sequencer_if.sv
// control_sequencer_if: opcode/memory handshake and datapath strobe bundle for the instruction sequencer
interface control_sequencer_if #(parameter int CNT_W = 16);
   logic             start;
   logic [7:0]       d;
   logic             ir_i;
   logic             ir_hlt;
   logic             mem_ack;
   logic             mem_req;
   logic             mem_we;
   logic [1:0]       ar_sel;
   logic             ir_ld;
   logic             pc_inc;
   logic             pc_ld;
   logic             dr_ld;
   logic             alu_go;
   logic             reg_go;
   logic [7:0]       opc;
   logic [2:0]       state;
   logic             halted;
   logic             mem_err;
   logic             illegal;
   logic [CNT_W-1:0] instr_cnt;
   modport master (
      output start, d, ir_i, ir_hlt, mem_ack,
      input  mem_req, mem_we, ar_sel, ir_ld, pc_inc, pc_ld, dr_ld, alu_go, reg_go,
             opc, state, halted, mem_err, illegal, instr_cnt
   );
   modport slave (
      input  start, d, ir_i, ir_hlt, mem_ack,
      output mem_req, mem_we, ar_sel, ir_ld, pc_inc, pc_ld, dr_ld, alu_go, reg_go,
             opc, state, halted, mem_err, illegal, instr_cnt
   );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/indirect/execute FSM driving memory handshake and datapath strobes
module control_sequencer #(
   parameter int WAIT_MAX = 15,
   parameter int CNT_W    = 16
) (
   input logic                clk,
   input logic                rst,
   control_sequencer_if.slave bus
);
   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] FETCH     = 3'd1;
   localparam logic [2:0] READ_IR   = 3'd2;
   localparam logic [2:0] DECODE    = 3'd3;
   localparam logic [2:0] INDIR     = 3'd4;
   localparam logic [2:0] EXEC_MEM  = 3'd5;
   localparam logic [2:0] EXEC_DONE = 3'd6;
   localparam logic [2:0] HALT      = 3'd7;
   logic [2:0]       state, nxt;
   logic [7:0]       opc;
   logic [7:0]       wait_cnt;
   logic [CNT_W-1:0] cnt;
   logic             mem_err;
   logic             is_alu, mem_req, timeout, retire;
   assign is_alu  = |opc[2:0];
   assign mem_req = state == READ_IR || state == INDIR ||
                    (state == EXEC_MEM && (is_alu || opc[3] || opc[5]));
   assign timeout = mem_req && !bus.mem_ack && wait_cnt == 8'(WAIT_MAX - 1);
   always_comb begin
      nxt = state;
      case (state)
         IDLE:      nxt = bus.start ? FETCH : IDLE;
         FETCH:     nxt = READ_IR;
         READ_IR:   nxt = bus.mem_ack ? DECODE : READ_IR;
         DECODE:    nxt = bus.d[7] ? (bus.ir_hlt ? HALT : FETCH) :
                          bus.d[6] ? FETCH : bus.ir_i ? INDIR : EXEC_MEM;
         INDIR:     nxt = bus.mem_ack ? EXEC_MEM : INDIR;
         EXEC_MEM:  nxt = (is_alu || opc[5]) ? (bus.mem_ack ? EXEC_DONE : EXEC_MEM) :
                          opc[3] ? (bus.mem_ack ? FETCH : EXEC_MEM) : FETCH;
         EXEC_DONE: nxt = FETCH;
         default:   nxt = HALT;
      endcase
      if (timeout) nxt = HALT;
   end
   assign retire = (nxt == FETCH && (state == DECODE || state == EXEC_MEM || state == EXEC_DONE)) ||
                   (state == DECODE && nxt == HALT);
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         opc      <= '0;
         wait_cnt <= '0;
         cnt      <= '0;
         mem_err  <= 1'b0;
      end else begin
         state    <= nxt;
         opc      <= state == DECODE ? bus.d : opc;
         wait_cnt <= (mem_req && !bus.mem_ack) ? wait_cnt + 8'd1 : 8'd0;
         cnt      <= retire ? cnt + CNT_W'(1) : cnt;
         mem_err  <= mem_err | timeout;
      end
   end
   assign bus.mem_req   = mem_req;
   assign bus.mem_we    = state == EXEC_MEM && !is_alu && (opc[3] || opc[5]);
   assign bus.ar_sel    = state == FETCH ? 2'b01 :
                          (state == DECODE && !bus.d[7] && !bus.d[6]) ? 2'b10 :
                          (state == INDIR && bus.mem_ack) ? 2'b11 : 2'b00;
   assign bus.ir_ld     = state == READ_IR && bus.mem_ack;
   assign bus.pc_inc    = (state == READ_IR && bus.mem_ack) || (state == EXEC_DONE && opc[5]);
   assign bus.pc_ld     = (state == EXEC_MEM && !is_alu && !opc[3] && opc[4]) ||
                          (state == EXEC_DONE && opc[5]);
   assign bus.dr_ld     = state == EXEC_MEM && is_alu && bus.mem_ack;
   assign bus.alu_go    = state == EXEC_DONE && is_alu;
   assign bus.reg_go    = state == DECODE && bus.d[7] && !bus.ir_hlt;
   assign bus.illegal   = state == DECODE && !bus.d[7] && bus.d[6];
   assign bus.opc       = opc;
   assign bus.state     = state;
   assign bus.halted    = state == HALT;
   assign bus.mem_err   = mem_err;
   assign bus.instr_cnt = cnt;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed instruction sequences with a queued-expectation scoreboard
module tb_control_sequencer;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   control_sequencer_if #(.CNT_W(16)) bus();
   control_sequencer #(.WAIT_MAX(15), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
   typedef enum {S_STATE, S_REQ, S_WE, S_AR, S_IR_LD, S_PC_INC, S_PC_LD, S_DR_LD, S_ALU,
                 S_REG, S_OPC, S_HALTED, S_ERR, S_ILL, S_CNT, S_STROBES} sig_e;
   typedef struct {sig_e sig; logic [31:0] val;} exp_t;
   exp_t q[$];
   int tests = 0;
   int fails = 0;
   function automatic logic [31:0] probe(sig_e s);
      case (s)
         S_STATE:  return 32'(bus.state);
         S_REQ:    return 32'(bus.mem_req);
         S_WE:     return 32'(bus.mem_we);
         S_AR:     return 32'(bus.ar_sel);
         S_IR_LD:  return 32'(bus.ir_ld);
         S_PC_INC: return 32'(bus.pc_inc);
         S_PC_LD:  return 32'(bus.pc_ld);
         S_DR_LD:  return 32'(bus.dr_ld);
         S_ALU:    return 32'(bus.alu_go);
         S_REG:    return 32'(bus.reg_go);
         S_OPC:    return 32'(bus.opc);
         S_HALTED: return 32'(bus.halted);
         S_ERR:    return 32'(bus.mem_err);
         S_ILL:    return 32'(bus.illegal);
         S_CNT:    return 32'(bus.instr_cnt);
         default:  return 32'({bus.mem_req, bus.mem_we, bus.ar_sel, bus.ir_ld, bus.pc_inc, bus.pc_ld,
                                bus.dr_ld, bus.alu_go, bus.reg_go, bus.illegal});
      endcase
   endfunction
   task automatic want(sig_e s, logic [31:0] v);
      q.push_back('{s, v});
   endtask
   task automatic settle();
      exp_t e;
      logic [31:0] obs;
      #1;
      while (q.size() > 0) begin
         e = q.pop_front();
         obs = probe(e.sig);
         tests++;
         assert (obs === e.val) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", e.sig.name(), obs, e.val, $time);
         end
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic hs(logic [2:0] st, int nw);
      for (int i = 0; i <= nw; i++) begin
         bus.mem_ack = (i == nw);
         want(S_STATE, 32'(st));
         want(S_REQ, 1);
         if (i < nw) begin
            settle();
            cyc();
         end
      end
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
   initial begin
      rst = 1'b1; bus.start = 1'b0; bus.d = '0; bus.ir_i = 1'b0; bus.ir_hlt = 1'b0; bus.mem_ack = 1'b0;
      cyc(); cyc();
      want(S_STATE, 0); want(S_OPC, 0); want(S_CNT, 0); want(S_ERR, 0); want(S_STROBES, 0); want(S_HALTED, 0);
      settle();
      rst = 1'b0; bus.start = 1'b1; want(S_STATE, 0); settle(); cyc();
      bus.start = 1'b0; want(S_STATE, 1); want(S_AR, 1); want(S_REQ, 0); settle(); cyc();
      hs(3'd2, 0); want(S_WE, 0); want(S_IR_LD, 1); want(S_PC_INC, 1); settle(); cyc();
      bus.mem_ack = 1'b0; bus.d = 8'h04; bus.ir_i = 1'b0;
      want(S_STATE, 3); want(S_AR, 2); want(S_REQ, 0); settle(); cyc();
      hs(3'd5, 0); want(S_OPC, 8'h04); want(S_DR_LD, 1); want(S_WE, 0); settle(); cyc();
      bus.mem_ack = 1'b0; want(S_STATE, 6); want(S_ALU, 1); settle(); cyc();
      want(S_STATE, 1); want(S_ALU, 0); want(S_CNT, 1); settle(); cyc();
      bus.d = 8'h02; bus.ir_i = 1'b1;
      hs(3'd2, 3); want(S_IR_LD, 1); settle(); cyc();
      bus.mem_ack = 1'b0; want(S_STATE, 3); want(S_AR, 2); settle(); cyc();
      hs(3'd4, 3); want(S_AR, 3); settle(); cyc();
      hs(3'd5, 3); want(S_OPC, 8'h02); want(S_DR_LD, 1); settle(); cyc();
      bus.mem_ack = 1'b0; want(S_STATE, 6); want(S_ALU, 1); settle(); cyc();
      want(S_STATE, 1); want(S_CNT, 2); settle(); cyc();
      bus.d = 8'h08; bus.ir_i = 1'b0;
      hs(3'd2, 0); want(S_WE, 0); settle(); cyc();
      bus.mem_ack = 1'b0; want(S_STATE, 3); want(S_WE, 0); settle(); cyc();
      hs(3'd5, 0); want(S_WE, 1); want(S_DR_LD, 0); settle(); cyc();
      bus.mem_ack = 1'b0; want(S_STATE, 1); want(S_WE, 0); want(S_CNT, 3); settle(); cyc();
      bus.d = 8'h80; bus.ir_hlt = 1'b0;
      hs(3'd2, 0); settle(); cyc();
      bus.mem_ack = 1'b0; want(S_STATE, 3); want(S_REG, 1); settle(); cyc();
      want(S_STATE, 1); want(S_REG, 0); want(S_CNT, 4); settle(); cyc();
      bus.d = 8'h40;
      hs(3'd2, 0); settle(); cyc();
      bus.mem_ack = 1'b0; want(S_ILL, 1); want(S_AR, 0); settle(); cyc();
      want(S_STATE, 1); want(S_ILL, 0); want(S_CNT, 5); settle(); cyc();
      bus.d = 8'h10;
      hs(3'd2, 0); settle(); cyc();
      bus.mem_ack = 1'b0; want(S_STATE, 3); settle(); cyc();
      want(S_STATE, 5); want(S_PC_LD, 1); want(S_REQ, 0); settle(); cyc();
      want(S_STATE, 1); want(S_CNT, 6); settle(); cyc();
      bus.d = 8'h20;
      hs(3'd2, 0); settle(); cyc();
      bus.mem_ack = 1'b0; want(S_STATE, 3); settle(); cyc();
      hs(3'd5, 1); want(S_WE, 1); settle(); cyc();
      bus.mem_ack = 1'b0; want(S_STATE, 6); want(S_PC_LD, 1); want(S_PC_INC, 1); settle(); cyc();
      want(S_STATE, 1); want(S_CNT, 7); settle(); cyc();
      bus.d = 8'h80; bus.ir_hlt = 1'b1;
      hs(3'd2, 0); settle(); cyc();
      bus.mem_ack = 1'b0; want(S_STATE, 3); want(S_REG, 0); settle(); cyc();
      bus.start = 1'b1;
      want(S_STATE, 7); want(S_HALTED, 1); want(S_CNT, 8); want(S_STROBES, 0); settle(); cyc();
      bus.mem_ack = 1'b1; want(S_STATE, 7); want(S_STROBES, 0); want(S_OPC, 8'h80); settle(); cyc();
      rst = 1'b1; bus.start = 1'b0; bus.mem_ack = 1'b0; cyc();
      want(S_STATE, 0); want(S_OPC, 0); want(S_CNT, 0); want(S_STROBES, 0); want(S_HALTED, 0); settle();
      rst = 1'b0; bus.start = 1'b1; settle(); cyc();
      bus.start = 1'b0; settle(); cyc();
      for (int i = 0; i < 15; i++) begin
         want(S_STATE, 2); want(S_ERR, 0); settle(); cyc();
      end
      want(S_STATE, 7); want(S_ERR, 1); want(S_CNT, 0); want(S_HALTED, 1); settle();
      rst = 1'b1; cyc();
      rst = 1'b0; bus.start = 1'b1; want(S_ERR, 0); want(S_STATE, 0); settle(); cyc();
      bus.start = 1'b0; settle(); cyc();
      for (int i = 0; i < 3; i++) begin
         want(S_STATE, 2); settle(); cyc();
      end
      rst = 1'b1; want(S_REQ, 1); settle(); cyc();
      rst = 1'b0;
      want(S_STATE, 0); want(S_REQ, 0); want(S_OPC, 0); want(S_CNT, 0); settle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
